mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 219 +++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO: tx falls two edges after a store into an idle block.
// Stores to a full FIFO are dropped and flagged in sticky OVF unless a pop lands on the same edge.

module mmio_uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];

  // A pop on the same edge frees the slot, so a full FIFO can still take the push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);
  localparam int          CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q;
  logic [15:0]   baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          ovf_q;
  logic          ovf_d;

  logic [1:0]    offset;
  logic          push;
  logic          sts_wr;
  logic          pop;
  logic          baud_end;
  logic          busy;
  logic [7:0]    head_dat;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [31:0]   status;
  logic          unused_bits;

  assign unused_bits = ^{wdata[31:8], addr[1:0]};

  assign hit    = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset = addr[3:2];
  assign push   = we & hit & (offset == 2'd0);
  assign sts_wr = we & hit & (offset == 2'd1);

  assign baud_end = (baud_q == BAUD_LAST);
  assign busy     = (state_q != IDLE);
  // The shifter reloads either from idle or straight out of the stop bit, giving back-to-back frames.
  assign pop      = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & baud_end));

  mmio_uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (wdata[7:0]),
    .pop_i      (pop),
    .pop_dat_o  (head_dat),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Set beats clear when both hit the same edge.
  always_comb begin
    ovf_d = ovf_q;
    if (sts_wr && wdata[3]) begin
      ovf_d = 1'b0;
    end
    if (push && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  assign status = {16'h0000, 8'(fifo_count), 4'h0, ovf_q, busy, fifo_empty, fifo_full};
  assign rdata  = (hit && offset == 2'd1) ? status : 32'h0000_0000;
  assign tx     = tx_q;
  assign irq    = fifo_empty & ~busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= ovf_d;

      // tx follows the state one cycle later, so every bit still lasts CLKS_PER_BIT cycles.
      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shift_q[0];
        default: tx_q <= 1'b1;
      endcase

      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q <= head_dat;
            baud_q  <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= head_dat;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled 1 time unit after the falling edge.

module tb_mmio_uart_tx;
  localparam int CPB = 4;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        hit;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] samples;
  logic [127:0] exp_bits;
  logic         busy_all;
  logic         high_all;

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .BASE_ADDR    (32'h0000_0100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .hit   (hit),
    .rdata (rdata),
    .tx    (tx),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w);
    addr  = a;
    wdata = d;
    we    = w;
  endtask

  // Expected tx waveform of n consecutive 8N1 frames, one sample per clock, index = time order.
  function automatic logic [127:0] frames(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input int n);
    logic [127:0] v;
    logic [7:0]   b;
    logic         bv;
    v = '0;
    for (int f = 0; f < n; f++) begin
      b = (f == 0) ? b0 : (f == 1) ? b1 : b2;
      for (int k = 0; k < 10; k++) begin
        bv = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
        for (int c = 0; c < CPB; c++) begin
          v[f*40 + k*CPB + c] = bv;
        end
      end
    end
    return v;
  endfunction

  // First sample is taken immediately; addr is expected to point at STATUS.
  task automatic capture(input int n, output logic [127:0] s, output logic ball);
    s    = '0;
    ball = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      s[i] = tx;
      if (i < 36) ball = ball & rdata[2];
    end
  endtask

  initial begin
    reset = 1'b1;
    bus(32'h104, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_status", rdata, 128'h2);
    check("reset_irq", irq, 1);
    check("reset_tx", tx, 1);
    check("status_hit", hit, 1);

    // Single frame 0x55 from idle.
    @(negedge clk);
    bus(32'h100, 32'hFFFF_FF55, 1'b1);
    #1;
    check("txdata_hit", hit, 1);
    @(negedge clk);
    bus(32'h104, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    check("status_after_pop", rdata, 128'h6);
    @(negedge clk);
    #1;
    capture(40, samples, busy_all);
    check("frame_55", samples, frames(8'h55, 8'h00, 8'h00, 1));
    check("busy_during_frame", busy_all, 1);
    @(negedge clk);
    #1;
    check("irq_after_frame", irq, 1);
    check("status_after_frame", rdata, 128'h2);

    // Three back-to-back stores give 120 contiguous cycles.
    @(negedge clk);
    bus(32'h100, 32'h01, 1'b1);
    @(negedge clk);
    bus(32'h100, 32'h02, 1'b1);
    @(negedge clk);
    bus(32'h100, 32'h03, 1'b1);
    @(negedge clk);
    bus(32'h104, 32'h0, 1'b0);
    #1;
    check("status_count2", rdata, 128'h204);
    capture(120, samples, busy_all);
    check("frames_010203", samples, frames(8'h01, 8'h02, 8'h03, 3));
    @(negedge clk);
    #1;
    check("irq_after_three", irq, 1);

    // Overflow while frame A transmits, then store on the exact pop edge.
    @(negedge clk);
    bus(32'h100, 32'h0F, 1'b1);
    @(negedge clk);
    bus(32'h104, 32'h0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus(32'h100, 32'(i * 17), 1'b1);
    end
    @(negedge clk);
    bus(32'h104, 32'h8, 1'b1);
    #1;
    check("status_ovf", rdata, 128'h40D);
    @(negedge clk);
    bus(32'h104, 32'h0, 1'b0);
    #1;
    check("status_ovf_cleared", rdata, 128'h405);
    repeat (32) @(negedge clk);
    #1;
    check("stop_bit_a", tx, 1);
    bus(32'h100, 32'hAA, 1'b1);
    @(negedge clk);
    bus(32'h104, 32'h0, 1'b0);
    #1;
    check("store_on_pop", rdata, 128'h405);
    @(negedge clk);
    #1;
    check("no_gap_start", tx, 0);

    // Reset in the middle of frame B (data 0x00), with a store on the reset edge.
    repeat (6) @(negedge clk);
    #1;
    check("mid_data_tx", tx, 0);
    reset = 1'b1;
    bus(32'h100, 32'h77, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    bus(32'h104, 32'h0, 1'b0);
    #1;
    check("abort_tx", tx, 1);
    check("abort_status", rdata, 128'h2);
    check("abort_irq", irq, 1);
    high_all = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      high_all = high_all & tx;
    end
    check("no_frame_after_reset", high_all, 1);

    // Address decode outside the register window and reserved offsets.
    @(negedge clk);
    bus(32'h0FC, 32'h99, 1'b1);
    #1;
    check("hit_0fc", hit, 0);
    check("rdata_0fc", rdata, 128'h0);
    @(negedge clk);
    bus(32'h110, 32'h99, 1'b1);
    #1;
    check("hit_110", hit, 0);
    check("rdata_110", rdata, 128'h0);
    @(negedge clk);
    bus(32'h108, 32'hFF, 1'b1);
    #1;
    check("hit_108", hit, 1);
    check("rdata_108", rdata, 128'h0);
    @(negedge clk);
    bus(32'h104, 32'h0, 1'b0);
    #1;
    check("no_push_outside", rdata, 128'h2);
    check("tx_idle_end", tx, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
